// File: rtl/dcache_ctrl_if.sv
// Bus bundles for the data-cache miss controller: CPU access port, cache-group
// command port and memory line port. The controller is slave on cpu, master on cache/mem.
interface dcache_cpu_if #(parameter int ADDR_W = 32);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;

  modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
                  input  cpu_rdata, cpu_ready);
  modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
                  output cpu_rdata, cpu_ready);
endinterface

interface dcache_cache_if #(parameter int ADDR_W = 32, parameter int LINE_W = 256);
  logic              cache_enable;
  logic              cache_compare;
  logic              cache_read;
  logic [ADDR_W-1:0] cache_address;
  logic [31:0]       cache_data_in;
  logic [3:0]        cache_byte_w_en;
  logic [LINE_W-1:0] cache_data_line_in;
  logic              cache_hit;
  logic              cache_dirty;
  logic              cache_valid;
  logic [31:0]       cache_data_out;
  logic [ADDR_W-1:0] cache_address_out;
  logic [LINE_W-1:0] cache_data_line_out;

  modport master (output cache_enable, cache_compare, cache_read, cache_address,
                         cache_data_in, cache_byte_w_en, cache_data_line_in,
                  input  cache_hit, cache_dirty, cache_valid, cache_data_out,
                         cache_address_out, cache_data_line_out);
  modport slave  (input  cache_enable, cache_compare, cache_read, cache_address,
                         cache_data_in, cache_byte_w_en, cache_data_line_in,
                  output cache_hit, cache_dirty, cache_valid, cache_data_out,
                         cache_address_out, cache_data_line_out);
endinterface

interface dcache_mem_if #(parameter int ADDR_W = 32, parameter int LINE_W = 256);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wline;
  logic [LINE_W-1:0] mem_rline;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wline,
                  input  mem_rline, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wline,
                  output mem_rline, mem_ack);
endinterface

// File: rtl/dcache_ctrl.sv
// Write-back / write-allocate miss controller for the 2-way data cache group.
// Optional hit/miss statistics counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dcache_cpu_if.slave    cpu,
  dcache_cache_if.master cache,
  dcache_mem_if.master   mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]    hit_cnt_o,
  output logic [31:0]    miss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    VICTIM = 3'd2,
    WB     = 3'd3,
    FILL   = 3'd4,
    REFILL = 3'd5,
    RESP   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] victim_addr_q, victim_addr_d;
  logic [LINE_W-1:0] victim_line_q, victim_line_d;
  logic [LINE_W-1:0] fill_line_q, fill_line_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              enable_q, enable_d;
  logic              compare_q, compare_d;
  logic              read_q, read_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  // Next state, request/victim/refill latches, and output values for the state being entered
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    victim_addr_d = victim_addr_q;
    victim_line_d = victim_line_q;
    fill_line_d   = fill_line_q;
    rdata_d       = rdata_q;
    ready_d       = 1'b0;
    enable_d      = 1'b0;
    compare_d     = 1'b0;
    read_d        = 1'b0;
    mem_req_d     = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (cpu.cpu_req) begin
          we_d    = cpu.cpu_we;
          addr_d  = cpu.cpu_addr;
          wdata_d = cpu.cpu_wdata;
          be_d    = cpu.cpu_be;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (cache.cache_hit) begin
          if (!we_q) begin
            rdata_d = cache.cache_data_out;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = RESP;
        end else begin
          state_d = VICTIM;
        end
      end
      VICTIM: begin
        victim_addr_d = cache.cache_address_out;
        victim_line_d = cache.cache_data_line_out;
        if (cache.cache_valid && cache.cache_dirty) begin
          state_d = WB;
        end else begin
          state_d = FILL;
        end
      end
      WB: begin
        if (mem.mem_ack) begin
          state_d = FILL;
        end else begin
          state_d = WB;
        end
      end
      FILL: begin
        if (mem.mem_ack) begin
          fill_line_d = mem.mem_rline;
          state_d     = REFILL;
        end else begin
          state_d = FILL;
        end
      end
      REFILL:  state_d = LOOKUP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed for the upcoming state so they leave the flops glitch-free
    case (state_d)
      LOOKUP: begin
        enable_d  = 1'b1;
        compare_d = 1'b1;
        read_d    = ~we_d;
      end
      VICTIM: begin
        enable_d = 1'b1;
        read_d   = 1'b1;
      end
      WB: begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = victim_addr_d;
      end
      FILL: begin
        mem_req_d  = 1'b1;
        mem_addr_d = {addr_d[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      REFILL:  enable_d = 1'b1;
      RESP:    ready_d  = 1'b1;
      default: ready_d  = 1'b0;
    endcase
  end

  // Controller state and all registered outputs; reset drops mem_req immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      addr_q        <= {ADDR_W{1'b0}};
      wdata_q       <= 32'd0;
      be_q          <= 4'd0;
      victim_addr_q <= {ADDR_W{1'b0}};
      victim_line_q <= {LINE_W{1'b0}};
      fill_line_q   <= {LINE_W{1'b0}};
      rdata_q       <= 32'd0;
      ready_q       <= 1'b0;
      enable_q      <= 1'b0;
      compare_q     <= 1'b0;
      read_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      victim_addr_q <= victim_addr_d;
      victim_line_q <= victim_line_d;
      fill_line_q   <= fill_line_d;
      rdata_q       <= rdata_d;
      ready_q       <= ready_d;
      enable_q      <= enable_d;
      compare_q     <= compare_d;
      read_q        <= read_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  assign cpu.cpu_rdata            = rdata_q;
  assign cpu.cpu_ready            = ready_q;
  assign cache.cache_enable       = enable_q;
  assign cache.cache_compare      = compare_q;
  assign cache.cache_read         = read_q;
  assign cache.cache_address      = addr_q;
  assign cache.cache_data_in      = wdata_q;
  assign cache.cache_byte_w_en    = be_q;
  assign cache.cache_data_line_in = fill_line_q;
  assign mem.mem_req              = mem_req_q;
  assign mem.mem_we               = mem_we_q;
  assign mem.mem_addr             = mem_addr_q;
  assign mem.mem_wline            = victim_line_q;

`ifdef DCACHE_STATS_EN
  logic        retry_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Classify each access once, on its first LOOKUP; the post-refill retry is skipped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (state_q == REFILL) begin
        retry_q <= 1'b1;
      end else if (state_q == IDLE) begin
        retry_q <= 1'b0;
      end else begin
        retry_q <= retry_q;
      end
      if ((state_q == LOOKUP) && !retry_q) begin
        if (cache.cache_hit) begin
          hit_cnt_q <= hit_cnt_q + 32'd1;
        end else begin
          miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end else begin
        hit_cnt_q  <= hit_cnt_q;
        miss_cnt_q <= miss_cnt_q;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural 2-way LRU cache group, a
// fixed-latency memory, and scoreboard queues for CPU responses and memory transactions.
module tb_dcache_ctrl;
  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int MEM_LAT  = 2;
  localparam int HIT_LAT  = 2;
  localparam int MISS_LAT = HIT_LAT + 3 + (MEM_LAT + 1);
  localparam int DIRT_LAT = MISS_LAT + (MEM_LAT + 1);

  logic clk;
  logic rst_n;
  logic model_clr;
  logic stray_ack;

  dcache_cpu_if   #(.ADDR_W(ADDR_W))                  cpu_if ();
  dcache_cache_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) cache_if ();
  dcache_mem_if   #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) mem_if ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  dcache_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cpu    (cpu_if),
    .cache  (cache_if),
    .mem    (mem_if)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_pat(input logic [31:0] a, input int i);
    return 32'hDEAD_BEEF ^ (a ^ 32'h0000_0100) ^ 32'(i);
  endfunction

  function automatic logic [255:0] line_pat(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = word_pat(a, i);
    return l;
  endfunction

  // Behavioural cache group: invalid way first, else LRU victim
  logic         c_valid [256][2];
  logic         c_dirty [256][2];
  logic [18:0]  c_tag   [256][2];
  logic [255:0] c_data  [256][2];
  logic         c_lru   [256];
  logic [7:0]   idx_s;
  logic [18:0]  tag_s;
  logic [2:0]   word_s;
  logic         hit0_s, hit1_s, hw_s, vic_s;

  assign idx_s  = cache_if.cache_address[12:5];
  assign tag_s  = cache_if.cache_address[31:13];
  assign word_s = cache_if.cache_address[4:2];
  assign hit0_s = c_valid[idx_s][0] && (c_tag[idx_s][0] == tag_s);
  assign hit1_s = c_valid[idx_s][1] && (c_tag[idx_s][1] == tag_s);
  assign hw_s   = hit1_s;
  assign vic_s  = !c_valid[idx_s][0] ? 1'b0 : (!c_valid[idx_s][1] ? 1'b1 : c_lru[idx_s]);

  assign cache_if.cache_hit           = cache_if.cache_enable && cache_if.cache_compare && (hit0_s || hit1_s);
  assign cache_if.cache_data_out      = c_data[idx_s][hw_s][word_s*32 +: 32];
  assign cache_if.cache_valid         = c_valid[idx_s][vic_s];
  assign cache_if.cache_dirty         = c_dirty[idx_s][vic_s];
  assign cache_if.cache_address_out   = {c_tag[idx_s][vic_s], idx_s, 5'b0};
  assign cache_if.cache_data_line_out = c_data[idx_s][vic_s];

  always @(posedge clk) begin
    if (model_clr) begin
      for (int s = 0; s < 256; s++) begin
        c_valid[s][0] <= 1'b0;
        c_valid[s][1] <= 1'b0;
        c_dirty[s][0] <= 1'b0;
        c_dirty[s][1] <= 1'b0;
        c_lru[s]      <= 1'b0;
      end
    end else if (cache_if.cache_hit) begin
      c_lru[idx_s] <= ~hw_s;
      if (!cache_if.cache_read) begin
        for (int b = 0; b < 4; b++)
          if (cache_if.cache_byte_w_en[b])
            c_data[idx_s][hw_s][word_s*32 + b*8 +: 8] <= cache_if.cache_data_in[b*8 +: 8];
        c_dirty[idx_s][hw_s] <= 1'b1;
      end
    end else if (cache_if.cache_enable && !cache_if.cache_compare && !cache_if.cache_read) begin
      c_valid[idx_s][vic_s] <= 1'b1;
      c_dirty[idx_s][vic_s] <= 1'b0;
      c_tag[idx_s][vic_s]   <= tag_s;
      c_data[idx_s][vic_s]  <= cache_if.cache_data_line_in;
    end
  end

  // Memory model and transaction scoreboard
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] w1; } mem_exp_t;
  typedef struct packed { logic we; logic [31:0] rdata; logic [7:0] lat; } cpu_exp_t;
  mem_exp_t mem_q[$];
  cpu_exp_t cpu_q[$];
  mem_exp_t me;
  logic     ack_m, prev_req, prev_ack;
  int       mcnt;

  assign mem_if.mem_ack   = ack_m | stray_ack;
  assign mem_if.mem_rline = line_pat(mem_if.mem_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m    <= 1'b0;
      mcnt     <= 0;
      prev_req <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      prev_req <= mem_if.mem_req;
      prev_ack <= mem_if.mem_ack;
      if (prev_req && !prev_ack) chk("mem_req_held", mem_if.mem_req, 1);
      if (ack_m) begin
        ack_m <= 1'b0;
        mcnt  <= 0;
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", mem_q.size(), 1);
        end else begin
          me = mem_q.pop_front();
          chk("mem_we", mem_if.mem_we, me.we);
          chk("mem_addr", mem_if.mem_addr, me.addr);
          chk("mem_cache_enable", cache_if.cache_enable, 0);
          if (me.we) chk("mem_wline_w1", mem_if.mem_wline[63:32], me.w1);
        end
      end else if (mem_if.mem_req) begin
        if (mcnt == MEM_LAT - 1) begin
          ack_m <= 1'b1;
          mcnt  <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] w1);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.w1 = w1;
    mem_q.push_back(e);
  endtask

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_rdata, input int exp_lat,
                           input bit first_hit, input bit stray);
    cpu_exp_t ce, got;
    int   lat;
    logic saw_req;
    ce.we = we; ce.rdata = exp_rdata; ce.lat = 8'(exp_lat);
    cpu_q.push_back(ce);
    if (first_hit) exp_hits++; else exp_misses++;
    cpu_if.cpu_req   = 1'b1;
    cpu_if.cpu_we    = we;
    cpu_if.cpu_addr  = addr;
    cpu_if.cpu_wdata = wdata;
    cpu_if.cpu_be    = be;
    @(posedge clk); #1;
    lat = 1;
    saw_req = mem_if.mem_req;
    cpu_if.cpu_addr  = addr ^ 32'hFFFF_FFE0;
    cpu_if.cpu_wdata = ~wdata;
    cpu_if.cpu_be    = ~be;
    cpu_if.cpu_we    = ~we;
    stray_ack = stray;
    while (!cpu_if.cpu_ready && lat < 64) begin
      @(posedge clk); #1;
      stray_ack = 1'b0;
      saw_req   = saw_req | mem_if.mem_req;
      lat++;
    end
    stray_ack = 1'b0;
    cpu_if.cpu_req = 1'b0;
    got = cpu_q.pop_front();
    chk("cpu_ready_seen", cpu_if.cpu_ready, 1);
    chk("latency", lat, got.lat);
    if (!got.we) chk("cpu_rdata", cpu_if.cpu_rdata, got.rdata);
    chk("resp_cache_enable", cache_if.cache_enable, 0);
    if (first_hit) chk("hit_no_mem_req", saw_req, 0);
    @(posedge clk); #1;
    chk("ready_one_cycle", cpu_if.cpu_ready, 0);
    chk("mem_q_drained", mem_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_n = 1'b0; model_clr = 1'b1; stray_ack = 1'b0;
    cpu_if.cpu_req = 1'b0; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 32'd0;
    cpu_if.cpu_wdata = 32'd0; cpu_if.cpu_be = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ready", cpu_if.cpu_ready, 0);
    chk("rst_cpu_rdata", cpu_if.cpu_rdata, 0);
    chk("rst_cache_enable", cache_if.cache_enable, 0);
    chk("rst_cache_compare", cache_if.cache_compare, 0);
    chk("rst_cache_read", cache_if.cache_read, 0);
    chk("rst_cache_address", cache_if.cache_address, 0);
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_mem_we", mem_if.mem_we, 0);
    chk("rst_mem_addr", mem_if.mem_addr, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 model_clr = 1'b0;
    @(posedge clk); #1;

    // Cold load 0x100: clean miss, fill only
    exp_mem(1'b0, 32'h0000_0100, 32'd0);
    do_access(1'b0, 32'h0000_0100, 32'd0, 4'h0, word_pat(32'h100, 0), MISS_LAT, 1'b0, 1'b0);
    // Repeat load hits; a stray mem_ack during LOOKUP is ignored
    do_access(1'b0, 32'h0000_0100, 32'd0, 4'h0, word_pat(32'h100, 0), HIT_LAT, 1'b1, 1'b1);
    // Partial store then readback of the merged word
    do_access(1'b1, 32'h0000_0104, 32'h0000_ABCD, 4'b0011, 32'd0, HIT_LAT, 1'b1, 1'b0);
    do_access(1'b0, 32'h0000_0104, 32'd0, 4'h0, {word_pat(32'h100, 1) >> 16, 16'hABCD}, HIT_LAT, 1'b1, 1'b0);
    // Set 8 conflicts: the dirty 0x100 line ends up as the LRU victim for 0x6100
    exp_mem(1'b0, 32'h0000_2100, 32'd0);
    do_access(1'b0, 32'h0000_2100, 32'd0, 4'h0, word_pat(32'h2100, 0), MISS_LAT, 1'b0, 1'b0);
    do_access(1'b0, 32'h0000_0104, 32'd0, 4'h0, 32'hDEAD_ABCD, HIT_LAT, 1'b1, 1'b0);
    exp_mem(1'b0, 32'h0000_4100, 32'd0);
    do_access(1'b0, 32'h0000_4100, 32'd0, 4'h0, word_pat(32'h4100, 0), MISS_LAT, 1'b0, 1'b0);
    exp_mem(1'b1, 32'h0000_0100, 32'hDEAD_ABCD);
    exp_mem(1'b0, 32'h0000_6100, 32'd0);
    do_access(1'b0, 32'h0000_6100, 32'd0, 4'h0, word_pat(32'h6100, 0), DIRT_LAT, 1'b0, 1'b0);
`ifdef DCACHE_STATS_EN
    chk("stats_hit", hit_cnt, exp_hits);
    chk("stats_miss", miss_cnt, exp_misses);
`endif

    // Reset in the middle of a fill
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 32'h0000_0A00;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!mem_if.mem_req && waited < 32);
    chk("fill_reached", mem_if.mem_req, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_mem_req", mem_if.mem_req, 0);
    chk("rst_async_enable", cache_if.cache_enable, 0);
    chk("rst_async_ready", cpu_if.cpu_ready, 0);
    cpu_if.cpu_req = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
`ifdef DCACHE_STATS_EN
    chk("stats_hit_rst", hit_cnt, 0);
    chk("stats_miss_rst", miss_cnt, 0);
`endif
    exp_hits = 0; exp_misses = 0;
    @(posedge clk); #1 stray_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      stray_ack = 1'b0;
      chk("post_rst_mem_req", mem_if.mem_req, 0);
      chk("post_rst_ready", cpu_if.cpu_ready, 0);
      chk("post_rst_enable", cache_if.cache_enable, 0);
    end
    do_access(1'b0, 32'h0000_4100, 32'd0, 4'h0, word_pat(32'h4100, 0), HIT_LAT, 1'b1, 1'b0);
`ifdef DCACHE_STATS_EN
    chk("stats_hit_end", hit_cnt, exp_hits);
    chk("stats_miss_end", miss_cnt, exp_misses);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
